// File: rtl/fp_depth_test_master.sv
// Depth-test stage: drives the FP comparator handshake and maps its result
// through the depth function. Optional stats counters: FP_DEPTH_STATS_EN.
module fp_depth_test_master #(
  parameter int ID_W         = 8,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            frag_valid,
  output logic            frag_ready,
  input  logic [31:0]     frag_z,
  input  logic [31:0]     buf_z,
  input  logic [ID_W-1:0] frag_id,
  input  logic [2:0]      depth_func,
  input  logic            depth_wr_en,
  input  logic            cmp_ready,
  output logic            cmp_data_valid,
  input  logic            cmp_calc_done,
  output logic            cmp_read_done,
  output logic [31:0]     cmp_a,
  output logic [31:0]     cmp_b,
  input  logic [2:0]      cmp_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_pass,
  output logic            out_zwr,
  output logic [31:0]     out_z,
  output logic [ID_W-1:0] out_id,
`ifdef FP_DEPTH_STATS_EN
  input  logic            stats_clr,
  output logic [31:0]     pass_cnt,
  output logic [31:0]     fail_cnt,
`endif
  output logic            cmp_timeout
);

  localparam int CW = $clog2(WAIT_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_func;
  logic            r_wren;
  logic [31:0]     r_cmp_a;
  logic [31:0]     r_cmp_b;
  logic            r_pass;
  logic            r_zwr;
  logic [31:0]     r_z;
  logic [ID_W-1:0] r_id;
  logic            r_tmo;

  logic            w_acc;
  logic            w_triv;
  logic            w_dv;
  logic            w_rd;
  logic            w_tmo;
  logic            w_verdict;

  // Non-canonical result encodings fall through as unordered.
  function automatic logic f_verdict(
    input logic [2:0] fn,
    input logic [2:0] res
  );
    logic gt, eq, lt;
    gt = (res == 3'b100);
    eq = (res == 3'b010);
    lt = (res == 3'b001);
    unique case (fn)
      3'd0:    f_verdict = 1'b0;
      3'd1:    f_verdict = lt;
      3'd2:    f_verdict = eq;
      3'd3:    f_verdict = lt | eq;
      3'd4:    f_verdict = gt;
      3'd5:    f_verdict = ~eq;
      3'd6:    f_verdict = gt | eq;
      default: f_verdict = 1'b1;
    endcase
  endfunction

  assign w_triv    = (depth_func == 3'd0) ||
                     (depth_func == 3'd7);
  assign w_verdict = f_verdict(r_func, cmp_result);

  always_comb begin
    w_next = r_state;
    w_acc  = 1'b0;
    w_dv   = 1'b0;
    w_rd   = 1'b0;
    w_tmo  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (frag_valid) begin
          w_acc  = 1'b1;
          w_next = w_triv ? S_OUT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmp_ready && !cmp_calc_done) begin
          w_dv   = 1'b1;
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cmp_calc_done) begin
          w_rd   = 1'b1;
          w_next = S_OUT;
        end else if (r_cnt == CW'(WAIT_TIMEOUT - 1)) begin
          w_tmo  = 1'b1;
          w_next = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_func  <= 3'd0;
      r_wren  <= 1'b0;
      r_cmp_a <= 32'd0;
      r_cmp_b <= 32'd0;
      r_pass  <= 1'b0;
      r_zwr   <= 1'b0;
      r_z     <= 32'd0;
      r_id    <= '0;
      r_tmo   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_z    <= frag_z;
        r_id   <= frag_id;
        r_func <= depth_func;
        r_wren <= depth_wr_en;
        if (w_triv) begin
          r_pass <= (depth_func == 3'd7);
          r_zwr  <= (depth_func == 3'd7) & depth_wr_en;
        end else begin
          r_cmp_a <= frag_z;
          r_cmp_b <= buf_z;
        end
      end
      if (r_state == S_WAIT) begin
        if (w_rd) begin
          r_pass <= w_verdict;
          r_zwr  <= w_verdict & r_wren;
          r_cnt  <= '0;
        end else if (w_tmo) begin
          r_tmo  <= 1'b1;
          r_pass <= 1'b0;
          r_zwr  <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_cnt  <= r_cnt + 1'b1;
        end
      end
    end
  end

`ifdef FP_DEPTH_STATS_EN
  logic [31:0] r_pass_cnt;
  logic [31:0] r_fail_cnt;
  logic        w_fire;

  assign w_fire = (r_state == S_OUT) & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_cnt <= 32'd0;
      r_fail_cnt <= 32'd0;
    end else if (stats_clr) begin
      r_pass_cnt <= 32'd0;
      r_fail_cnt <= 32'd0;
    end else if (w_fire) begin
      if (r_pass && (r_pass_cnt != 32'hFFFF_FFFF))
        r_pass_cnt <= r_pass_cnt + 32'd1;
      if (!r_pass && (r_fail_cnt != 32'hFFFF_FFFF))
        r_fail_cnt <= r_fail_cnt + 32'd1;
    end
  end

  assign pass_cnt = r_pass_cnt;
  assign fail_cnt = r_fail_cnt;
`endif

  assign frag_ready     = (r_state == S_IDLE);
  assign cmp_data_valid = w_dv;
  assign cmp_read_done  = w_rd;
  assign cmp_a          = r_cmp_a;
  assign cmp_b          = r_cmp_b;
  assign out_valid      = (r_state == S_OUT);
  assign out_pass       = r_pass;
  assign out_zwr        = r_zwr;
  assign out_z          = r_z;
  assign out_id         = r_id;
  assign cmp_timeout    = r_tmo;

endmodule

// File: tb/tb_fp_depth_test_master.sv
// Bench for fp_depth_test_master: behavioural comparator stub plus
// a float-ordering reference model, directed and random fragments.
module tb_fp_depth_test_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frag_valid;
  logic        frag_ready;
  logic [31:0] frag_z;
  logic [31:0] buf_z;
  logic [7:0]  frag_id;
  logic [2:0]  depth_func;
  logic        depth_wr_en;
  logic        cmp_ready;
  logic        cmp_data_valid;
  logic        cmp_calc_done;
  logic        cmp_read_done;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic [2:0]  cmp_result;
  logic        out_valid;
  logic        out_ready;
  logic        out_pass;
  logic        out_zwr;
  logic [31:0] out_z;
  logic [7:0]  out_id;
  logic        cmp_timeout;
`ifdef FP_DEPTH_STATS_EN
  logic        stats_clr;
  logic [31:0] pass_cnt;
  logic [31:0] fail_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int dv_cnt = 0;
  int exp_dv = 0;
  int exp_pc = 0;
  int exp_fc = 0;
  logic tb_hang = 1'b0;

  always #5 clk = ~clk;

  fp_depth_test_master #(.ID_W(8), .WAIT_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_z(frag_z), .buf_z(buf_z), .frag_id(frag_id),
    .depth_func(depth_func), .depth_wr_en(depth_wr_en),
    .cmp_ready(cmp_ready), .cmp_data_valid(cmp_data_valid),
    .cmp_calc_done(cmp_calc_done), .cmp_read_done(cmp_read_done),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_result(cmp_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pass(out_pass), .out_zwr(out_zwr),
    .out_z(out_z), .out_id(out_id),
`ifdef FP_DEPTH_STATS_EN
    .stats_clr(stats_clr), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt),
`endif
    .cmp_timeout(cmp_timeout)
  );

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic longint fkey(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [2:0] fcmp(input logic [31:0] a,
                                      input logic [31:0] b);
    if (is_nan(a) || is_nan(b)) return 3'b000;
    if (fkey(a) > fkey(b)) return 3'b100;
    if (fkey(a) < fkey(b)) return 3'b001;
    return 3'b010;
  endfunction

  function automatic logic ref_pass(input logic [2:0] fn,
                                    input logic [2:0] r);
    case (fn)
      3'd0: return 1'b0;
      3'd1: return r == 3'b001;
      3'd2: return r == 3'b010;
      3'd3: return (r == 3'b001) || (r == 3'b010);
      3'd4: return r == 3'b100;
      3'd5: return r != 3'b010;
      3'd6: return (r == 3'b100) || (r == 3'b010);
      default: return 1'b1;
    endcase
  endfunction

  // Comparator stub: result three cycles after the operand strobe.
  initial begin : stub
    logic s_dv, s_rd;
    logic [31:0] s_a, s_b;
    int delay;
    logic hung;
    delay = 0;
    hung = 1'b0;
    cmp_ready = 1'b1;
    cmp_calc_done = 1'b0;
    cmp_result = 3'b000;
    forever begin
      @(negedge clk);
      s_dv = cmp_data_valid;
      s_rd = cmp_read_done;
      s_a = cmp_a;
      s_b = cmp_b;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        delay = 0;
        hung = 1'b0;
        cmp_calc_done = 1'b0;
      end else begin
        if (s_rd) cmp_calc_done = 1'b0;
        if (delay > 0) begin
          delay--;
          if (delay == 0) cmp_calc_done = 1'b1;
        end
        if (s_dv) begin
          dv_cnt++;
          cmp_result = fcmp(s_a, s_b);
          if (tb_hang) hung = 1'b1;
          else delay = 2;
        end
        if (!tb_hang) hung = 1'b0;
      end
      cmp_ready = !((delay > 0) || cmp_calc_done || hung);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_frag_ready", 64'(frag_ready), 64'd1);
    chk("rst_dv", 64'(cmp_data_valid), 64'd0);
    chk("rst_rd", 64'(cmp_read_done), 64'd0);
    chk("rst_cmp_ab", {cmp_a, cmp_b}, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_pass_zwr", {62'd0, out_pass, out_zwr}, 64'd0);
    chk("rst_out_z_id", {24'd0, out_z, out_id}, 64'd0);
    chk("rst_timeout", 64'(cmp_timeout), 64'd0);
  endtask

  task automatic send(input logic [31:0] z, input logic [31:0] bz,
                      input logic [7:0] id, input logic [2:0] fn,
                      input logic wr);
    int n;
    @(posedge clk);
    #1;
    frag_z = z;
    buf_z = bz;
    frag_id = id;
    depth_func = fn;
    depth_wr_en = wr;
    frag_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frag_ready && n < 200);
    if (!frag_ready) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    frag_valid = 1'b0;
    if (fn != 3'd0 && fn != 3'd7) exp_dv++;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  // Leaves the bench in the OUT cycle's negedge; caller releases it.
  task automatic frag_at_out(input string tag,
                             input logic [31:0] z,
                             input logic [31:0] bz,
                             input logic [7:0] id,
                             input logic [2:0] fn,
                             input logic wr,
                             output logic ep);
    int lat, elat;
    send(z, bz, id, fn, wr);
    wait_out(lat);
    if (fn == 3'd0 || fn == 3'd7) elat = 1;
    else if (tb_hang) elat = 66;
    else elat = 5;
    ep = (fn != 3'd0 && fn != 3'd7 && tb_hang) ? 1'b0 :
         ref_pass(fn, fcmp(z, bz));
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_pass_zwr"}, {62'd0, out_pass, out_zwr},
        {62'd0, ep, ep & wr});
    chk({tag, "_z_id"}, {24'd0, out_z, out_id}, {24'd0, z, id});
    if (ep) exp_pc++;
    else exp_fc++;
  endtask

  task automatic frag(input string tag, input logic [31:0] z,
                      input logic [31:0] bz, input logic [7:0] id,
                      input logic [2:0] fn, input logic wr);
    logic ep;
    frag_at_out(tag, z, bz, id, fn, wr, ep);
    @(negedge clk);
    chk({tag, "_idle"}, {62'd0, out_valid, frag_ready}, 64'd1);
  endtask

  function automatic logic [31:0] rnd_f();
    logic [31:0] pool [8];
    pool = '{32'h0, 32'h80000000, 32'h3F800000, 32'hBF800000,
             32'h40000000, 32'h7FC00000, 32'h7F800000,
             32'hFF800000};
    if ($urandom_range(0, 1) == 0) return pool[$urandom_range(0, 7)];
    return {1'($urandom), 8'($urandom_range(120, 134)),
            23'($urandom)};
  endfunction

  initial begin : main
    logic ep;
    int snap, bad;
    logic [31:0] rz, rb;
    rst_n = 1'b0;
    frag_valid = 1'b0;
    frag_z = 32'd0;
    buf_z = 32'd0;
    frag_id = 8'd0;
    depth_func = 3'd0;
    depth_wr_en = 1'b0;
    out_ready = 1'b1;
`ifdef FP_DEPTH_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();
    rst_n = 1'b1;

    frag("less", 32'h3F800000, 32'h40000000, 8'h01, 3'd1, 1'b1);
    frag("greater", 32'hBF800000, 32'h80000000, 8'h02, 3'd4, 1'b1);
    frag("equal", 32'h00000000, 32'h80000000, 8'h03, 3'd2, 1'b1);
    frag("noteq_nan", 32'h7FC00000, 32'h3F800000, 8'h04, 3'd5, 1'b1);
    frag("lequal_nan", 32'h7FC00000, 32'h3F800000, 8'h05, 3'd3, 1'b1);
    snap = dv_cnt;
    frag("always", 32'h12345678, 32'h0, 8'h06, 3'd7, 1'b0);
    frag("never", 32'h3F800000, 32'h40000000, 8'h07, 3'd0, 1'b1);
    chk("trivial_no_dv", 64'(dv_cnt), 64'(snap));

    out_ready = 1'b0;
    frag_at_out("stall", 32'h40000000, 32'h3F800000, 8'h08, 3'd6,
                1'b1, ep);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || out_pass !== ep || out_zwr !== ep ||
          out_z !== 32'h40000000 || out_id !== 8'h08) bad++;
    end
    chk("stall_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", 64'(out_valid), 64'd0);

    for (int i = 0; i < 3; i++)
      frag("b2b", 32'h3F800000 + 32'(i), 32'h3F800001, 8'(8'h10 + i),
           3'd3, 1'b1);

    for (int i = 0; i < 24; i++) begin
      rz = rnd_f();
      rb = ($urandom_range(0, 3) == 0) ? rz : rnd_f();
      frag("rand", rz, rb, 8'($urandom), 3'($urandom),
           1'($urandom));
    end

    tb_hang = 1'b1;
    frag("timeout", 32'h3F800000, 32'h40000000, 8'h20, 3'd1, 1'b1);
    chk("timeout_flag", 64'(cmp_timeout), 64'd1);
    tb_hang = 1'b0;
    frag("after_tmo", 32'h3F800000, 32'h40000000, 8'h21, 3'd1, 1'b1);
    chk("timeout_sticky", 64'(cmp_timeout), 64'd1);

`ifdef FP_DEPTH_STATS_EN
    chk("stats_pass", 64'(pass_cnt), 64'(exp_pc));
    chk("stats_fail", 64'(fail_cnt), 64'(exp_fc));
`endif

    send(32'h3F800000, 32'h40000000, 8'h30, 3'd1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_pc = 0;
    exp_fc = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("reset_abandon", 64'(bad), 64'd0);
    frag("post_reset", 32'h40000000, 32'h40000000, 8'h31, 3'd2, 1'b0);
    chk("dv_per_compare", 64'(dv_cnt), 64'(exp_dv));
`ifdef FP_DEPTH_STATS_EN
    chk("stats_pass_rst", 64'(pass_cnt), 64'(exp_pc));
    chk("stats_fail_rst", 64'(fail_cnt), 64'(exp_fc));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
